// File: rtl/axi_apb_pkg.sv
// axi_apb_pkg: shared types and helpers for the AXI4-Lite to APB3 multi-slave bridge
// Contents: resp_t (AXI response codes), state_t (bridge FSM states),
//           idx_width() (width of the slave index field decoded from the address).
package axi_apb_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        WRESP,
        RRESP
    } state_t;

    // The index field is one value wider than the slave count needs, so an
    // out-of-range window (e.g. index 5 with 4 slaves) decodes to DECERR
    // instead of silently aliasing onto a real slave.
    function automatic int idx_width(input int num_slaves);
        return $clog2(num_slaves + 1);
    endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// apb_slave_decoder: address to one-hot APB slave select
// Ports: addr  - request address
//        sel   - one-hot select, all zero when the window is unmapped
//        valid - index field addresses an existing slave
module apb_slave_decoder
    import axi_apb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_ADDR_W = 12
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  valid
);

    localparam int IDX_W = idx_width(NUM_SLAVES);

    logic [IDX_W-1:0] idx;
    logic             unused_addr;

    assign idx         = addr[SLV_ADDR_W +: IDX_W];
    assign valid       = idx < IDX_W'(NUM_SLAVES);
    assign sel         = NUM_SLAVES'(valid) << idx;
    assign unused_addr = ^addr;

endmodule

// File: rtl/axi_lite_apb_multi_bridge.sv
// axi_lite_apb_multi_bridge: AXI4-Lite slave to APB3 master serving NUM_SLAVES peripherals
// Ports: clk, rst_n (async active-low)
//        AXI4-Lite slave: aw*, w*, b*, ar*, r* channels, one holding register each for AW/W/AR
//        APB3 master: PADDR/PWRITE/PWDATA/PSTRB/PSEL/PENABLE out, PRDATA/PREADY/PSLVERR per slave in
// Option: define APB_TIMEOUT_EN to abort ACCESS phases after TIMEOUT wait cycles with SLVERR.
module axi_lite_apb_multi_bridge
    import axi_apb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int SLV_ADDR_W = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [ADDR_W-1:0]            araddr,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [ADDR_W-1:0]            PADDR,
    output logic                         PWRITE,
    output logic [DATA_W-1:0]            PWDATA,
    output logic [DATA_W/8-1:0]          PSTRB,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    state_t                  state;
    logic                    aw_full, w_full, ar_full, last_wr;
    logic [ADDR_W-1:0]       aw_addr, ar_addr, sel_addr;
    logic [DATA_W-1:0]       w_data, prdata_sel;
    logic [DATA_W/8-1:0]     w_strb;
    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    dec_valid, wr_pend, rd_pend, pick_wr;
    logic                    ready_sel, err_sel, expired, done;
    resp_t                   acc_resp;

    assign awready  = !aw_full;
    assign wready   = !w_full;
    assign arready  = !ar_full;
    assign wr_pend  = aw_full && w_full;
    assign rd_pend  = ar_full;
    // On contention the direction not served last wins; last_wr resets low so writes go first.
    assign pick_wr  = wr_pend && (!rd_pend || !last_wr);
    assign sel_addr = pick_wr ? aw_addr : ar_addr;

    apb_slave_decoder #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_ADDR_W (SLV_ADDR_W)
    ) u_dec (
        .addr  (sel_addr),
        .sel   (dec_sel),
        .valid (dec_valid)
    );

    // PSEL stays one-hot through ACCESS, so it doubles as the per-slave response mux select.
    assign ready_sel = |(PREADY & PSEL);
    assign err_sel   = |(PSLVERR & PSEL);
    assign acc_resp  = (ready_sel && !err_sel) ? OKAY : SLVERR;
    assign done      = ready_sel || expired;

    always_comb begin
        prdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            prdata_sel = prdata_sel | (PSEL[i] ? PRDATA[i*DATA_W +: DATA_W] : '0);
    end

`ifdef APB_TIMEOUT_EN
    logic [7:0] to_cnt;
    assign expired = to_cnt == 8'(TIMEOUT);
`else
    localparam int unused_timeout = TIMEOUT;
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            ar_full <= 1'b0;
            last_wr <= 1'b0;
            aw_addr <= '0;
            ar_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            PSTRB   <= '0;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
            rvalid  <= 1'b0;
            rresp   <= OKAY;
            rdata   <= '0;
`ifdef APB_TIMEOUT_EN
            to_cnt  <= '0;
`endif
        end else begin
            if (awvalid && awready) begin
                aw_full <= 1'b1;
                aw_addr <= awaddr;
            end
            if (wvalid && wready) begin
                w_full <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (arvalid && arready) begin
                ar_full <= 1'b1;
                ar_addr <= araddr;
            end
            case (state)
                IDLE: if (wr_pend || rd_pend) begin
                    last_wr <= pick_wr;
                    PADDR   <= sel_addr;
                    PWRITE  <= pick_wr;
                    PWDATA  <= w_data;
                    PSTRB   <= pick_wr ? w_strb : '0;
                    PSEL    <= dec_sel;
`ifdef APB_TIMEOUT_EN
                    to_cnt  <= '0;
`endif
                    if (dec_valid) state <= SETUP;
                    else if (pick_wr) begin
                        state  <= WRESP;
                        bvalid <= 1'b1;
                        bresp  <= DECERR;
                    end else begin
                        state  <= RRESP;
                        rvalid <= 1'b1;
                        rresp  <= DECERR;
                        rdata  <= '0;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        state   <= PWRITE ? WRESP : RRESP;
                        if (PWRITE) begin
                            bvalid <= 1'b1;
                            bresp  <= acc_resp;
                        end else begin
                            rvalid <= 1'b1;
                            rresp  <= acc_resp;
                            rdata  <= ready_sel ? prdata_sel : '0;
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else to_cnt <= to_cnt + 8'd1;
`endif
                end
                WRESP: if (bready) begin
                    bvalid  <= 1'b0;
                    aw_full <= 1'b0;
                    w_full  <= 1'b0;
                    state   <= IDLE;
                end
                RRESP: if (rready) begin
                    rvalid  <= 1'b0;
                    ar_full <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
